// File: rtl/ser_word_pkg.sv
// rtl/ser_word_pkg.sv - shared state enum, default width and counter sizing for ser_word_tx (SER_WORD_TX_PARITY_EN adds the parity state)
package ser_word_pkg;

   localparam int DEFAULT_WIDTH = 16;

`ifdef SER_WORD_TX_PARITY_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } tx_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1
   } tx_state_e;
`endif

   // Bit counter width; a one-bit word still needs a one-bit counter.
   function automatic int ctr_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/bit_ctr.sv
// rtl/bit_ctr.sv - enabled up-counter with synchronous clear, saturating at MAX with terminal-count flag
module bit_ctr #(
   parameter int MAX = 15,
   parameter int CW  = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [CW-1:0] MAX_V = CW'(MAX);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tc_o = (cnt_q == MAX_V);

   // Clear wins over count; the count never runs past MAX so it cannot wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ser_word_tx.sv
// rtl/ser_word_tx.sv - parallel-to-serial word transmitter with stall enable; SER_WORD_TX_PARITY_EN appends an even-parity bit
module ser_word_tx
   import ser_word_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             en,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last
);

   tx_state_e        state_q;
   tx_state_e        state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic             head;
   logic             ctr_clr;
   logic             ctr_en;
   logic             ctr_tc;

   bit_ctr #(
      .MAX (WIDTH - 1),
      .CW  (ctr_width(WIDTH))
   ) u_bit_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (ctr_clr),
      .en_i  (ctr_en),
      .tc_o  (ctr_tc)
   );

   // Ready only while idle, and held low for as long as reset is asserted.
   assign in_ready = rst_n && (state_q == ST_IDLE);

   assign head = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

`ifdef SER_WORD_TX_PARITY_EN
   logic parity_q;

   // Even parity of the word is captured at load, before shifting destroys it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_q <= 1'b0;
      end else if ((state_q == ST_IDLE) && in_valid) begin
         parity_q <= ^in_data;
      end
   end
`endif

   // Next-state, shifter and serial outputs; nothing advances while en is low.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      ctr_clr    = 1'b0;
      ctr_en     = 1'b0;
      sout       = 1'b0;
      sout_valid = 1'b0;
      sout_last  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               shreg_d = in_data;
               ctr_clr = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sout       = head;
            sout_valid = en;
`ifndef SER_WORD_TX_PARITY_EN
            sout_last  = en && ctr_tc;
`endif
            if (en) begin
               shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
               ctr_en  = 1'b1;
               if (ctr_tc) begin
`ifdef SER_WORD_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_IDLE;
`endif
               end
            end
         end
`ifdef SER_WORD_TX_PARITY_EN
         ST_PARITY: begin
            sout       = parity_q;
            sout_valid = en;
            sout_last  = en;
            if (en) begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and shift register; reset discards any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
      end
   end

endmodule

// File: doc/ser_word_tx.md
SER_WORD_TX -- requirements
Module: ser_word_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 16: parallel word width in bits.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, WIDTH bits: parallel word to transmit.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-008 SHALL have port en, input, 1 bit: shift enable; 0 stalls the serial stream.
REQ-009 SHALL have port sout, output, 1 bit: serial data bit.
REQ-010 SHALL have port sout_valid, output, 1 bit: sout carries a valid bit this cycle.
REQ-011 SHALL have port sout_last, output, 1 bit: marks the final bit of the frame.

Function
REQ-012 SHALL implement states IDLE, SHIFT and PARITY; PARITY exists only when the REQ-022 macro is defined.
REQ-013 SHALL drive in_ready=1 only in IDLE; a handshake is in_valid & in_ready at a clock edge.
REQ-014 SHALL, on a handshake, load in_data into the shift register, clear the bit counter and enter SHIFT on the same edge.
REQ-015 SHALL, in SHIFT, drive sout = current head bit (per MSB_FIRST) and sout_valid=en; first bit appears the cycle after the handshake.
REQ-016 SHALL advance shift register and counter only on edges where en=1; with en=0, sout, counter and state hold and sout_valid=0.
REQ-017 SHALL present each bit for exactly one enabled cycle; with en held at 1, a frame occupies WIDTH consecutive cycles.
REQ-018 SHALL assert sout_last with the bit at counter=WIDTH-1 (parity build: on the parity bit instead).
REQ-019 SHALL return to IDLE on the enabled edge after the last bit; in_ready rises the following cycle, so one idle cycle separates frames.
REQ-020 SHALL ignore in_data/in_valid outside IDLE; no word is lost or overwritten mid-frame.
REQ-021 SHALL size the counter as clog2(WIDTH) bits with no wrap past WIDTH-1.

Configuration
REQ-022 SHALL, when SER_WORD_TX_PARITY_EN is defined, latch the even parity (XOR of in_data) at load and send it as one extra enabled cycle in PARITY after the data bits; undefined: frame is WIDTH bits, no PARITY state.

Reset
REQ-023 SHALL, on rst_n=0, immediately force state=IDLE, counter=0, shift register=0, sout=0, sout_valid=0, sout_last=0, in_ready=0 while reset is asserted.
REQ-024 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.
REQ-025 SHALL, when reset asserts mid-frame, discard the frame; no partial bits resume after release.

Structure
REQ-026 SHALL place the state enumeration and the default WIDTH constant in shared package ser_word_pkg.
REQ-027 SHALL use one sub-module, bit_ctr, an enabled counter with clear and terminal-count output.

Verification
REQ-028 SHALL cover: WIDTH=16, MSB_FIRST=1, en=1, load 16'hA5C3 -> sout 1010010111000011 on 16 consecutive cycles, sout_last on cycle 16.
REQ-029 SHALL cover: MSB_FIRST=0, load 16'h0001 -> first sout=1, then 15 zeros; in_ready=0 throughout.
REQ-030 SHALL cover: load 16'hFFFF, en=0 for 3 cycles after bit 4 -> sout_valid=0 for those 3 cycles, sout holds, all 16 ones still delivered.
REQ-031 SHALL cover: in_valid held with new word 16'h1234 during a frame -> ignored until IDLE, then sent after exactly one idle cycle.
REQ-032 SHALL cover: rst_n pulsed low at bit 7 of 16'hBEEF -> outputs 0 immediately, in_ready=1 the cycle after release, no remaining bits emitted.
REQ-033 SHALL cover, with SER_WORD_TX_PARITY_EN: load 16'h0007 -> 16 data bits then parity bit 1 with sout_last; 17-cycle frame.
